// File: rtl/wrf_pkg.sv
// Shared types and constants for the working-register-file
// nibble write demultiplexer.
package wrf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WRITE   = 2'b10
  } state_t;

  localparam int NIB_W_DEF   = 4;
  localparam int NIBBLES_DEF = 4;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Counter width; a floor of one bit keeps the
  // declaration legal for degenerate parameter values.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrf_nibble_demux_if.sv
// Nibble stream handshake into the write demultiplexer.
// The master offers nibbles; the slave accepts them.
interface wrf_nibble_demux_if
  import wrf_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [NIB_W-1:0] in_nib;
  logic             in_sel;
  logic             abort;

  modport master (
    output in_valid,
    output in_nib,
    output in_sel,
    output abort,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_nib,
    input  in_sel,
    input  abort,
    output in_ready
  );

endinterface

// File: rtl/wrf_nibble_assembler.sv
// Slot-addressed shift register and nibble counter.
// Fills a word LSB-first and flags the final slot.
module wrf_nibble_assembler
  import wrf_pkg::*;
#(
  parameter int NIB_W   = NIB_W_DEF,
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int WORD_W  = NIB_W * NIBBLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [NIB_W-1:0]  nib,
  output logic [WORD_W-1:0] word_nxt,
  output logic              last
);

  localparam int CNT_W = cnt_w(NIBBLES);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  assign last = (cnt_q == CNT_W'(NIBBLES - 1));

  // Word as it will look once the offered nibble lands.
  always_comb begin
    word_nxt = word_q;
    word_nxt[int'(cnt_q)*NIB_W +: NIB_W] = nib;
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      word_d = word_nxt;
      cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/wrf_nibble_demux.sv
// Assembles nibbles into words and writes them to one
// of two bank registers with a one-cycle write strobe.
module wrf_nibble_demux
  import wrf_pkg::*;
#(
  parameter  int NIB_W   = NIB_W_DEF,
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int WORD_W  = NIB_W * NIBBLES
) (
  input  logic              sysclk,
  input  logic              sys_rst,
  wrf_nibble_demux_if.slave in_if,
  output logic              wr_stb,
  output logic              wr_bank,
  output logic [WORD_W-1:0] wr_word,
  output logic [WORD_W-1:0] bank0_q,
  output logic [WORD_W-1:0] bank1_q,
  output logic              busy
);

  generate
    if (NIBBLES < 2) begin : g_bad_nibbles
      $error("wrf_nibble_demux: NIBBLES must be >= 2");
    end
  endgenerate

  state_t            state_q;
  state_t            state_d;
  logic              sel_q;
  logic              sel_d;
  logic [WORD_W-1:0] bank0_d;
  logic [WORD_W-1:0] bank1_d;
  logic [WORD_W-1:0] wr_word_q;
  logic [WORD_W-1:0] wr_word_d;
  logic [WORD_W-1:0] word_nxt;
  logic              last;
  logic              accept;
  logic              clear;

  // abort wins over a nibble offered in the same cycle.
  assign accept = in_if.in_valid & in_if.in_ready
                & ~in_if.abort;
  assign clear  = (state_q == COLLECT) & in_if.abort;

  wrf_nibble_assembler #(
    .NIB_W   (NIB_W),
    .NIBBLES (NIBBLES),
    .WORD_W  (WORD_W)
  ) u_asm (
    .clk      (sysclk),
    .rst      (sys_rst),
    .load     (accept),
    .clear    (clear),
    .nib      (in_if.in_nib),
    .word_nxt (word_nxt),
    .last     (last)
  );

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) state_d = COLLECT;
      end
      (state_q == COLLECT): begin
        if (in_if.abort)       state_d = IDLE;
        else if (accept && last) state_d = WRITE;
      end
      (state_q == WRITE): begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_if.in_ready = (state_q != WRITE);
    busy           = (state_q != IDLE);
    wr_stb         = (state_q == WRITE);
  end

  // Banks load on the last accept so they are
  // already valid while wr_stb is high.
  always_comb begin
    sel_d     = sel_q;
    bank0_d   = bank0_q;
    bank1_d   = bank1_q;
    wr_word_d = wr_word_q;
    if (accept && state_q == IDLE) begin
      sel_d = in_if.in_sel;
    end
    if (accept && last) begin
      wr_word_d = word_nxt;
      if (sel_q == BANK1) bank1_d = word_nxt;
      else                bank0_d = word_nxt;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q     <= BANK0;
      bank0_q   <= '0;
      bank1_q   <= '0;
      wr_word_q <= '0;
    end else begin
      sel_q     <= sel_d;
      bank0_q   <= bank0_d;
      bank1_q   <= bank1_d;
      wr_word_q <= wr_word_d;
    end
  end

  assign wr_bank = sel_q;
  assign wr_word = wr_word_q;

endmodule

// File: tb/tb_wrf_nibble_demux.sv
// Bench for wrf_nibble_demux: table of words plus abort
// and async-reset sequences, checked via a scoreboard.
module tb_wrf_nibble_demux;

  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_stb;
  logic        wr_bank;
  logic [15:0] wr_word;
  logic [15:0] bank0_q;
  logic [15:0] bank1_q;
  logic        busy;

  wrf_nibble_demux_if #(.NIB_W(4)) bus ();

  wrf_nibble_demux #(.NIB_W(4), .NIBBLES(4)) dut (
    .sysclk  (sysclk),
    .sys_rst (sys_rst),
    .in_if   (bus),
    .wr_stb  (wr_stb),
    .wr_bank (wr_bank),
    .wr_word (wr_word),
    .bank0_q (bank0_q),
    .bank1_q (bank1_q),
    .busy    (busy)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic            sel;
    logic            tog;
    logic [3:0][3:0] nibs;
    int              gap;
    logic [15:0]     word;
  } vec_t;

  typedef struct packed {
    logic        bank;
    logic [15:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ex0 = '0;
  logic [15:0] ex1 = '0;
  int          n_pass = 0;
  int          n_tot = 0;
  vec_t        vecs[4];
  vec_t        v;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Offers n nibbles of v; pushes the expectation just
  // before the edge that accepts the 4th nibble.
  task automatic send_word(input vec_t w, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      bus.in_valid = 1'b1;
      bus.in_nib   = w.nibs[i];
      bus.in_sel   = (i == 0) ? w.sel : (w.sel ^ w.tog);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        if (bus.in_ready) begin
          if (i == 3) sb.push_back({w.sel, w.word});
          @(posedge sysclk);
          ok = 1'b1;
        end else begin
          @(negedge sysclk);
        end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      if (i < n - 1) begin
        for (int g = 0; g < w.gap; g++) begin
          @(negedge sysclk);
          bus.in_valid = 1'b0;
        end
      end
    end
    if (n == 4) begin
      @(negedge sysclk);
      chk("stb_latency", wr_stb, 1);
      chk("ready_low_in_write", bus.in_ready, 0);
    end
  endtask

  always @(negedge sysclk) begin
    if (!sys_rst && wr_stb) begin
      if (sb.size() == 0) begin
        chk("stb_unexpected", wr_stb, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.bank) ex1 = e.word;
        else        ex0 = e.word;
        chk("wr_bank", wr_bank, e.bank);
        chk("wr_word", wr_word, e.word);
        chk("bank0_q", bank0_q, ex0);
        chk("bank1_q", bank1_q, ex1);
      end
    end
  end

  initial begin
    vecs[0] = '{sel: 1'b1, tog: 1'b0,
                nibs: {4'hA, 4'hB, 4'hC, 4'hD},
                gap: 0, word: 16'hABCD};
    vecs[1] = '{sel: 1'b0, tog: 1'b1,
                nibs: {4'h4, 4'h3, 4'h2, 4'h1},
                gap: 0, word: 16'h4321};
    vecs[2] = '{sel: 1'b1, tog: 1'b0,
                nibs: {4'h4, 4'h3, 4'h2, 4'h1},
                gap: 2, word: 16'h4321};
    vecs[3] = '{sel: 1'b1, tog: 1'b1,
                nibs: {4'h0, 4'hF, 4'h0, 4'hF},
                gap: 1, word: 16'h0F0F};

    bus.in_valid = 1'b0;
    bus.in_nib   = '0;
    bus.in_sel   = 1'b0;
    bus.abort    = 1'b0;
    repeat (3) @(negedge sysclk);
    sys_rst = 1'b0;
    @(negedge sysclk);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_word", wr_word, 0);
    chk("rst_bank0", bank0_q, 0);
    chk("rst_bank1", bank1_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.in_ready, 1);

    for (int t = 0; t < 4; t++) send_word(vecs[t], 4);
    @(negedge sysclk);
    bus.in_valid = 1'b0;

    // Abort after two nibbles, with a nibble offered.
    v = '{sel: 1'b0, tog: 1'b0,
          nibs: {4'h0, 4'h0, 4'h8, 4'h9},
          gap: 0, word: 16'h0000};
    send_word(v, 2);
    @(negedge sysclk);
    bus.in_valid = 1'b1;
    bus.in_nib   = 4'hF;
    bus.abort    = 1'b1;
    @(negedge sysclk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.in_ready, 1);
    v = '{sel: 1'b0, tog: 1'b0,
          nibs: {4'h1, 4'h3, 4'h5, 4'h7},
          gap: 0, word: 16'h1357};
    send_word(v, 4);

    // Async reset with three nibbles held.
    v = '{sel: 1'b1, tog: 1'b0,
          nibs: {4'h0, 4'h7, 4'h6, 4'h5},
          gap: 0, word: 16'h0000};
    send_word(v, 3);
    @(negedge sysclk);
    bus.in_valid = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_bank0", bank0_q, 0);
    chk("arst_bank1", bank1_q, 0);
    chk("arst_wr_word", wr_word, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_wr_stb", wr_stb, 0);
    ex0 = '0;
    ex1 = '0;
    sb.delete();
    @(negedge sysclk);
    sys_rst = 1'b0;
    v = '{sel: 1'b1, tog: 1'b0,
          nibs: {4'h2, 4'h4, 4'h6, 4'h8},
          gap: 0, word: 16'h2468};
    send_word(v, 4);
    @(negedge sysclk);
    bus.in_valid = 1'b0;

    repeat (3) @(negedge sysclk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
